mem_handle_responder: RTL and testbench

// - Memory-side end of the mem_handle protocol: serves up to NPORTS initiators (FPU op FSMs) against one

---
 rtl/mem_handle_responder.sv | 175 +++++++++++++++++
 tb/tb_mem_handle_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_handle_responder.sv
// Memory-side responder for the mem_handle protocol: round-robin arbitration of NPORTS initiators
// onto one DEPTH x 32 word store. Optional bounds checking via `MEM_RESP_BOUNDS_CHECK_EN.
module mem_handle_responder #(
    parameter int unsigned NPORTS = 4,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic [NPORTS-1:0]        avail,
    input  logic [NPORTS-1:0]        r_en,
    input  logic [NPORTS-1:0]        w_en,
    input  logic [NPORTS*ADDR_W-1:0] ptr,
    input  logic [NPORTS*32-1:0]     data_store,
    output logic [NPORTS*32-1:0]     data_load,
    output logic [NPORTS-1:0]        done,
    output logic                     err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            gnt_q, gnt_d;
    logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]        ptr_q, ptr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic                     wr_q, wr_d;
    logic [NPORTS-1:0]        armed_q, armed_d;
    logic [NPORTS-1:0][31:0]  data_load_q, data_load_d;
    logic                     err_q, err_d;

    logic [31:0]              mem [DEPTH];
    logic [31:0]              rd_word;
    logic                     mem_we;
    logic                     oob;
    logic [NPORTS-1:0]        req;
    logic                     found;
    logic [PW-1:0]            sel;
    logic [PW-1:0]            rr_next;

`ifdef MEM_RESP_BOUNDS_CHECK_EN
    assign oob = (ptr_q >= ADDR_W'(DEPTH));
`else
    logic unused_ptr_bits;
    assign oob             = 1'b0;
    assign unused_ptr_bits = ^ptr_q;
`endif

    assign req     = avail & (r_en | w_en) & armed_q;
    assign rd_word = oob ? 32'hDEAD_BEEF : mem[ptr_q[IDX_W-1:0]];
    // rst_l gate keeps a write caught mid-ACCESS by reset from committing.
    assign mem_we  = (state_q == ACCESS) && wr_q && !oob && rst_l;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q[IDX_W-1:0]] <= wdata_q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            ptr_q       <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            armed_q     <= '1;
            data_load_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            ptr_q       <= ptr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            armed_q     <= armed_d;
            data_load_q <= data_load_d;
            err_q       <= err_d;
        end
    end

    // Rotating-priority search starting at rr_ptr
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NPORTS) begin
                idx = idx - NPORTS;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
    end

    always_comb begin
        rr_next = '0;
        if ((int'(gnt_q) + 1) < NPORTS) begin
            rr_next = gnt_q + 1'b1;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        ptr_d       = ptr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        armed_d     = armed_q;
        data_load_d = data_load_q;
        err_d       = err_q;

        for (int unsigned i = 0; i < NPORTS; i++) begin
            if (!avail[i]) begin
                armed_d[i] = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = sel;
                    ptr_d   = ptr[sel*ADDR_W +: ADDR_W];
                    wdata_d = data_store[sel*32 +: 32];
                    wr_d    = w_en[sel];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Read data lands on the same edge that raises done.
                if (!wr_q) begin
                    data_load_d[gnt_q] = rd_word;
                end
                state_d = RESP;
            end
            RESP: begin
                armed_d[gnt_q] = 1'b0;
                rr_ptr_d       = rr_next;
                err_d          = err_q | oob;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        done = '0;
        if (state_q == RESP) begin
            done[gnt_q] = 1'b1;
        end
    end

    assign data_load = data_load_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_handle_responder.sv
// Scoreboard bench for mem_handle_responder: stimulus pushes expected completions, a monitor
// branch pops and checks them on every done pulse.
module tb_mem_handle_responder;

    localparam int unsigned NP    = 4;
    localparam int unsigned DEPTH = 1024;
`ifdef MEM_RESP_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic            clk;
    logic            rst_l;
    logic [NP-1:0]   avail, r_en, w_en;
    logic [NP*32-1:0] ptr, data_store;
    logic [NP*32-1:0] data_load;
    logic [NP-1:0]   done;
    logic            err;

    mem_handle_responder #(.NPORTS(NP), .DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .avail      (avail),
        .r_en       (r_en),
        .w_en       (w_en),
        .ptr        (ptr),
        .data_store (data_store),
        .data_load  (data_load),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        int          port;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   done_cnt[NP];
    int   seen[NP];
    bit   hold[NP];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; initiators that saw done drop their request unless holding.
    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (done_cnt[p] != seen[p]) begin
                seen[p] = done_cnt[p];
                if (!hold[p]) begin
                    avail[p] = 1'b0;
                    r_en[p]  = 1'b0;
                    w_en[p]  = 1'b0;
                end
            end
        end
    endtask

    task automatic issue(input int p, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int lat, input logic [31:0] exp_dl,
                         input bit push);
        avail[p]              = 1'b1;
        r_en[p]               = rd;
        w_en[p]               = wr;
        ptr[p*32 +: 32]        = a;
        data_store[p*32 +: 32] = d;
        if (push) sbq.push_back('{p, cyc + lat, exp_dl});
    endtask

    task automatic wait_drop(input int p);
        for (int i = 0; i < 40 && avail[p]; i++) step();
        chk($sformatf("timeout_port%0d", p), {63'b0, avail[p]}, 64'd0);
    endtask

    task automatic single(input int p, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_dl);
        issue(p, rd, wr, a, d, 2, exp_dl, 1'b1);
        wait_drop(p);
        step();
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            done_cnt[p] = 0;
            seen[p]     = 0;
            hold[p]     = 1'b0;
        end
        rst_l = 1'b0;
        avail = '0; r_en = '0; w_en = '0; ptr = '0; data_store = '0;
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (done !== '0) begin
                        for (int p = 0; p < NP; p++) if (done[p]) done_cnt[p]++;
                        if (sbq.size() == 0) begin
                            chk("unexpected_done", {60'b0, done}, 64'd0);
                        end else begin
                            exp_t e;
                            e = sbq.pop_front();
                            chk($sformatf("done_port%0d", e.port), {60'b0, done}, 64'(1 << e.port));
                            chk($sformatf("done_cycle_p%0d", e.port), 64'(cyc), 64'(e.cyc));
                            chk($sformatf("data_load_p%0d", e.port), {32'b0, data_load[e.port*32 +: 32]},
                                {32'b0, e.data});
                        end
                    end
                end
            end
            begin : stimulus
                int start;
                repeat (3) @(posedge clk);
                #1;
                chk("reset_done", {60'b0, done}, 64'd0);
                chk("reset_data_load_lo", data_load[63:0], 64'd0);
                chk("reset_data_load_hi", data_load[127:64], 64'd0);
                chk("reset_err", {63'b0, err}, 64'd0);
                rst_l = 1'b1;
                step();

                // Write then read on port 0
                single(0, 1'b0, 1'b1, 32'd5, 32'h3F80_0000, 32'h0);
                single(0, 1'b1, 1'b0, 32'd5, 32'h0, 32'h3F80_0000);

                // rr_ptr is now 1: grant order 1, 2, 0
                issue(1, 1'b0, 1'b1, 32'd20, 32'h11, 2, 32'h0, 1'b1);
                issue(2, 1'b1, 1'b0, 32'd5, 32'h0, 5, 32'h3F80_0000, 1'b1);
                issue(0, 1'b0, 1'b1, 32'd21, 32'h22, 8, 32'h3F80_0000, 1'b1);
                wait_drop(1);
                wait_drop(2);
                wait_drop(0);
                step();

                // Port 3 keeps avail high after done: served once only
                hold[3] = 1'b1;
                start   = done_cnt[3];
                issue(3, 1'b1, 1'b0, 32'd20, 32'h0, 2, 32'h11, 1'b1);
                for (int i = 0; i < 40 && done_cnt[3] == start; i++) step();
                repeat (4) step();
                chk("hold_single_done", 64'(done_cnt[3] - start), 64'd1);
                avail[3] = 1'b0; r_en[3] = 1'b0;
                hold[3]  = 1'b0;
                step();
                single(3, 1'b0, 1'b1, 32'd30, 32'h33, 32'h11);

                // avail without enables is never granted
                start    = done_cnt[1];
                avail[1] = 1'b1;
                repeat (5) step();
                chk("no_enable_ignored", 64'(done_cnt[1] - start), 64'd0);
                avail[1] = 1'b0;
                step();

                // Both enables: write, data_load untouched
                single(1, 1'b1, 1'b0, 32'd20, 32'h0, 32'h11);
                single(1, 1'b1, 1'b1, 32'd7, 32'h2, 32'h11);
                single(0, 1'b1, 1'b0, 32'd7, 32'h0, 32'h2);

                // Reset during ACCESS of a write abandons it
                single(2, 1'b0, 1'b1, 32'd9, 32'h55, 32'h3F80_0000);
                start = done_cnt[2];
                issue(2, 1'b0, 1'b1, 32'd9, 32'hA, 2, 32'h0, 1'b0);
                step();
                #2;
                rst_l = 1'b0;
                avail = '0; r_en = '0; w_en = '0;
                #1;
                chk("reset_mid_done", {60'b0, done}, 64'd0);
                repeat (2) step();
                chk("reset_mid_data_load", {32'b0, data_load[63:32]}, 64'd0);
                rst_l = 1'b1;
                step();
                chk("reset_mid_no_done", 64'(done_cnt[2] - start), 64'd0);
                single(2, 1'b1, 1'b0, 32'd9, 32'h0, 32'h55);

                // Out-of-range pointer
                single(0, 1'b0, 1'b1, 32'd3, 32'h1234, 32'h0);
                chk("err_before_oob", {63'b0, err}, 64'd0);
                single(0, 1'b0, 1'b1, DEPTH + 3, 32'h7, 32'h0);
                chk("err_after_oob", {63'b0, err}, {63'b0, BC});
                single(0, 1'b1, 1'b0, 32'd3, 32'h0, BC ? 32'h1234 : 32'h7);
                single(1, 1'b1, 1'b0, DEPTH + 3, 32'h0, BC ? 32'hDEAD_BEEF : 32'h7);
                chk("err_final", {63'b0, err}, {63'b0, BC});

                repeat (5) step();
                chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
            end
            begin : watchdog
                repeat (20000) @(posedge clk);
                mismatched++;
                $display("FAIL watchdog: simulation time limit reached");
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
